// File: rtl/wire_cut_judge.sv
// Judge stage for the bomb-defusal game: runs the round countdown, scores wire cuts
// against the maze target, counts strikes and reports DEFUSED/EXPLODED.
module wire_cut_judge #(
    parameter int TICKS_PER_SEC   = 100000000,
    parameter int START_SECONDS   = 90,
    parameter int MAX_STRIKES     = 3,
    parameter int PENALTY_SECONDS = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [2:0] wire_to_cut,
    input  logic [2:0] cut_sw,
    output logic [1:0] state,
    output logic [7:0] time_left,
    output logic [1:0] strikes,
    output logic       strike_pulse,
    output logic       defused,
    output logic       exploded
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_DEFUSED  = 2'd2,
        S_EXPLODED = 2'd3
    } state_e;

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0] START_VAL = 8'(START_SECONDS);

    // Unsigned subtraction clamped at zero; time never wraps below 0.
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input int b);
        if (b <= 0) begin
            return a;
        end
        if (int'(a) > b) begin
            return a - 8'(b);
        end
        return 8'd0;
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        time_q, time_d;
    logic [1:0]        strikes_q, strikes_d;
    logic              pulse_q, pulse_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        cut_prev_q;

    logic [2:0] new_cut;
    logic [2:0] target_mask;
    logic       target_valid;
    logic       tick_wrap;
    logic       wrong_cut;
    logic       right_cut;
    logic [7:0] t_dec;
    logic [7:0] t_pen;

    always_comb begin
        target_valid = 1'b1;
        target_mask  = 3'b000;
        case (wire_to_cut)
            3'd1:    target_mask = 3'b001;
            3'd2:    target_mask = 3'b010;
            3'd3:    target_mask = 3'b100;
            default: target_valid = 1'b0;
        endcase
    end

    assign new_cut   = cut_sw & ~cut_prev_q;
    assign right_cut = target_valid && (new_cut == target_mask);
    assign wrong_cut = (new_cut != 3'b000) && !right_cut;
    assign tick_wrap = (tick_q == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        strikes_d = strikes_q;
        pulse_d   = 1'b0;
        tick_d    = tick_q;
        t_dec     = time_q;
        t_pen     = time_q;

        case (state_q)
            S_ARMED: begin
                tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                t_dec  = tick_wrap ? sat_sub8(time_q, 1) : time_q;
                t_pen  = sat_sub8(t_dec, PENALTY_SECONDS);
                time_d = t_dec;
                // Timer expiry outranks any cut landing in the same cycle.
                if (tick_wrap && (t_dec == 8'd0)) begin
                    state_d = S_EXPLODED;
                end else if (wrong_cut) begin
                    time_d    = t_pen;
                    strikes_d = (strikes_q == 2'd3) ? 2'd3 : strikes_q + 2'd1;
                    pulse_d   = 1'b1;
                    if ((int'(strikes_q) + 1 >= MAX_STRIKES) || (t_pen == 8'd0)) begin
                        state_d = S_EXPLODED;
                    end
                end else if (right_cut) begin
                    state_d = S_DEFUSED;
                end
            end
            default: begin
                if (start) begin
                    state_d   = S_ARMED;
                    time_d    = START_VAL;
                    strikes_d = 2'd0;
                    tick_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            time_q     <= 8'd0;
            strikes_q  <= 2'd0;
            pulse_q    <= 1'b0;
            tick_q     <= '0;
            cut_prev_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            strikes_q  <= strikes_d;
            pulse_q    <= pulse_d;
            tick_q     <= tick_d;
            cut_prev_q <= cut_sw;
        end
    end

    assign state        = state_q;
    assign time_left    = time_q;
    assign strikes      = strikes_q;
    assign strike_pulse = pulse_q;
    assign defused      = (state_q == S_DEFUSED);
    assign exploded     = (state_q == S_EXPLODED);

endmodule

// File: tb/tb_wire_cut_judge.sv
// Directed bench for wire_cut_judge: a per-cycle vector table plus hand-written
// countdown and mid-round reset sequences.
module tb_wire_cut_judge;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic [2:0] wire_to_cut;
    logic [2:0] cut_sw;
    logic [1:0] state;
    logic [7:0] time_left;
    logic [1:0] strikes;
    logic       strike_pulse;
    logic       defused;
    logic       exploded;

    int n_checks = 0;
    int n_errors = 0;

    wire_cut_judge #(
        .TICKS_PER_SEC  (4),
        .START_SECONDS  (5),
        .MAX_STRIKES    (3),
        .PENALTY_SECONDS(2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .start       (start),
        .wire_to_cut (wire_to_cut),
        .cut_sw      (cut_sw),
        .state       (state),
        .time_left   (time_left),
        .strikes     (strikes),
        .strike_pulse(strike_pulse),
        .defused     (defused),
        .exploded    (exploded)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       start;
        logic [2:0] wtc;
        logic [2:0] cut;
        logic [1:0] st;
        logic [7:0] tl;
        logic [1:0] sk;
        logic       sp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [2:0] w, input logic [2:0] c,
                       input logic [1:0] st, input logic [7:0] tl,
                       input logic [1:0] sk, input logic sp);
        vec_t v;
        v.start = s; v.wtc = w; v.cut = c; v.st = st; v.tl = tl; v.sk = sk; v.sp = sp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [7:0] tl,
                             input logic [1:0] sk, input logic sp);
        check({tag, ".state"}, int'(state), int'(st));
        check({tag, ".time_left"}, int'(time_left), int'(tl));
        check({tag, ".strikes"}, int'(strikes), int'(sk));
        check({tag, ".strike_pulse"}, int'(strike_pulse), int'(sp));
        check({tag, ".defused"}, int'(defused), int'(st == 2'd2));
        check({tag, ".exploded"}, int'(exploded), int'(st == 2'd3));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Defuse on wire 2, freeze, re-arm with switch held, then defuse again.
        add(1, 2, 3'b000, 1, 5, 0, 0);
        add(0, 2, 3'b010, 2, 5, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 2, 3'b010, 2, 5, 0, 0);
        add(1, 2, 3'b010, 1, 5, 0, 0);
        add(0, 2, 3'b010, 1, 5, 0, 0);
        add(0, 2, 3'b000, 1, 5, 0, 0);
        add(0, 2, 3'b010, 2, 5, 0, 0);
        // Three strikes with target 1: 5 -> 3 -> 1 -> 0.
        add(1, 1, 3'b000, 1, 5, 0, 0);
        add(0, 1, 3'b010, 1, 3, 1, 1);
        add(0, 1, 3'b100, 1, 1, 2, 1);
        add(0, 1, 3'b110, 3, 0, 3, 1);
        add(0, 1, 3'b110, 3, 0, 3, 0);
        // Invalid target strike, triple cut = one strike, then timer expiry.
        add(1, 0, 3'b000, 1, 5, 0, 0);
        add(0, 0, 3'b001, 1, 3, 1, 1);
        add(0, 3, 3'b000, 1, 3, 1, 0);
        add(0, 3, 3'b111, 1, 1, 2, 1);
        add(0, 3, 3'b111, 3, 0, 2, 0);
        // Switch held before arming is not a cut; re-raising it is.
        add(0, 1, 3'b001, 3, 0, 2, 0);
        add(1, 1, 3'b001, 1, 5, 0, 0);
        add(0, 1, 3'b001, 1, 5, 0, 0);
        add(0, 1, 3'b000, 1, 5, 0, 0);
        add(0, 1, 3'b001, 2, 5, 0, 0);

        RESET = 1'b1; start = 1'b0; wire_to_cut = 3'd0; cut_sw = 3'b000;
        #3;
        check_all("reset", 0, 0, 0, 0);
        step();
        step();
        RESET = 1'b0;
        step();
        check_all("idle", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            start       = vecs[i].start;
            wire_to_cut = vecs[i].wtc;
            cut_sw      = vecs[i].cut;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tl, vecs[i].sk, vecs[i].sp);
        end

        // Countdown with no cuts: explodes exactly 20 cycles after start.
        start = 1'b1; cut_sw = 3'b000; wire_to_cut = 3'd1;
        step();
        start = 1'b0;
        check_all("cd_arm", 1, 5, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check_all($sformatf("cd%0d", k), (k < 20) ? 2'd1 : 2'd3, 8'(5 - k / 4), 0, 0);
        end

        // Reset mid-countdown with wire 3 held; held switch must not strike later.
        cut_sw = 3'b100;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check_all("pre_rst", 1, 4, 0, 0);
        #2 RESET = 1'b1;
        #1;
        check_all("mid_rst", 0, 0, 0, 0);
        step();
        RESET = 1'b0;
        step();
        check_all("post_rst", 0, 0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("rearm", 1, 5, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("held%0d", k), 1, 5, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
